muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the HI/LO multiply/divide resource for the execute stage of the MIPS core.
//  - Accepts MULT/MULTU/DIV/DIVU from the decoder's ALU control path.
//  - Runs a 1-cycle registered multiply or a 32-iteration radix-2 restoring divide.
//  - Holds the pipeline via stall_o while busy, then commits to the architectural HI/LO registers.
//  - Also services MTHI/MTLO writes.
// PARAMETERS
//  WIDTH      32   operand width; hi_o/lo_o are WIDTH each
//  DIV_ITERS  32   divide iterations, must equal WIDTH
// PORTS
//  clk        in   1      core clock
//  rst        in   1      synchronous, active-high reset
//  start_i    in   1      valid mul/div op in E stage; held stable while stall_o=1
//  op_i       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a_i        in   WIDTH  rs operand (dividend / multiplicand)
//  b_i        in   WIDTH  rt operand (divisor / multiplier)
//  flush_i    in   1      exception/eret flush; cancels any operation in flight
//  hi_we_i    in   1      MTHI write enable
//  lo_we_i    in   1      MTLO write enable
//  wdata_i    in   WIDTH  MTHI/MTLO data
//  stall_o    out  1      holds IF/ID/E; combinational
//  done_o     out  1      one-cycle pulse in the cycle HI/LO first shows a new mul/div result
//  hi_o       out  WIDTH  architectural HI
//  lo_o       out  WIDTH  architectural LO
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, hi_o=0, lo_o=0, done_o=0, stall_o=0.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE:
//   - start_i & !flush_i: latch op, |a|, |b|, sign flags; stall_o=1 this cycle.
//   - op[1]=0 -> MUL. op[1]=1 & b_i!=0 -> DIV with cnt=0. op[1]=1 & b_i==0 -> DONE.
//  MUL: stall_o=1; at the edge load {hi,lo} = signed (MULT) or unsigned (MULTU) 64-bit product; -> DONE.
//  DIV:
//   - stall_o=1; one quotient bit per cycle (shift, trial subtract, restore); cnt++.
//   - At cnt==DIV_ITERS-1 the edge loads lo=quotient, hi=remainder; -> DONE.
//   - DIV sign fix: quotient negated iff sign(a)!=sign(b); remainder takes sign(a).
//   - DIVU: no sign fix.
//  Divide by zero: no iteration; the edge leaving IDLE loads hi=a_i, lo={WIDTH{1'b1}}; -> DONE.
//  DONE:
//   - stall_o=0, done_o=1; start_i is ignored (same instruction still in E).
//   - -> IDLE next cycle.
//  Latency (start cycle to the DONE cycle, inclusive of stall):
//   - MULT/MULTU: 2 stall cycles, DONE in cycle 3.
//   - DIV/DIVU: 33 stall cycles, DONE in cycle 34.
//   - Divide by zero: 1 stall cycle, DONE in cycle 2.
//  Flush:
//   - In any state, flush_i -> IDLE next edge, cnt=0.
//   - HI/LO keep their pre-operation values; no done_o.
//   - stall_o drops in the flush cycle.
//  start_i & flush_i in IDLE: op is not accepted.
//  MTHI/MTLO:
//   - Honoured in IDLE and DONE.
//   - If a mul/div commit edge coincides with hi_we/lo_we, the commit wins.
//   - hi_we and lo_we may both be set and write both registers.
//  Widths: product is 2*WIDTH; the divide partial remainder is WIDTH+1 bits; cnt is $clog2(DIV_ITERS) bits.
//  Reset mid-operation: immediate return to reset values.
// STRUCTURE
//  Shared package mdu_defs:
//   - op codes MD_MULT/MD_MULTU/MD_DIV/MD_DIVU.
//   - state enum IDLE/MUL/DIV/DONE.
//   - used by alu_decoder so encodings cannot drift.
//  Sub-module div_radix2:
//   - iterative restoring core: start, |a|, |b| in; q, r, last out.
//   - muldiv_sequencer owns the FSM, the sign handling and HI/LO.
// TESTING
//  - MULT a=0xFFFFFFFE(-2), b=3 -> stall 2 cycles; DONE: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done_o 1 cycle.
//  - MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  - DIV a=-7 (0xFFFFFFF9), b=2 -> 33 stall cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//  - DIVU a=100, b=0 -> 1 stall cycle; hi=100, lo=0xFFFFFFFF.
//  - Flush on cycle 10 of DIVU 100/7 with prior hi=0x11, lo=0x22 -> stall_o drops in the flush cycle, FSM -> IDLE, hi=0x11, lo=0x22, no done_o.
//  - MTLO 0x55 in the DONE cycle of MULTU 2*3 -> lo=0x55 next cycle (hi=0); MTHI on a commit edge is overridden by the product.
//  - rst asserted mid-DIV -> next cycle stall_o=0, hi_o=lo_o=0.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mdu_defs
// Shared definitions for the HI/LO multiply/divide unit. The ALU decoder
// imports the same package so that the mul/div op encodings and the
// sequencer state encodings stay in one place.
//
// Contents
//   md_op_e        2-bit mul/div operation code (MULT, MULTU, DIV, DIVU)
//   ST_*           sequencer state encodings (IDLE, MUL, DIV, DONE)
//   md_is_div      true for DIV/DIVU
//   md_is_signed   true for MULT/DIV
// ----------------------------------------------------------------------------
package mdu_defs;

    // Operation codes as driven by the decoder's ALU control path.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states, kept as plain constants so older netlists and
    // waveform scripts that match on the raw encoding keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Bit 1 of the op code separates the divide group from the multiply group.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    // MULT and DIV treat their operands as two's complement values.
    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_radix2.sv
// ----------------------------------------------------------------------------
// div_radix2
// Iterative radix-2 restoring divider working on unsigned magnitudes. One
// quotient bit is produced per i_step cycle. The quotient/remainder outputs
// show the values that the current step will produce, so the owner can
// commit them on the same edge as the final step.
//
// Ports
//   clk         in   core clock
//   rst         in   synchronous, active-high reset
//   i_start     in   load dividend/divisor magnitudes and clear the count
//   i_step      in   perform one shift / trial-subtract / restore iteration
//   i_abort     in   drop the division in flight (count back to zero)
//   i_dividend  in   |a|
//   i_divisor   in   |b|, must be non-zero when stepping
//   o_q         out  quotient after the current step
//   o_r         out  remainder after the current step
//   o_last      out  the current step is the final iteration
// ----------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r,
    output logic             o_last
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    // One restoring iteration. The partial remainder is shifted left and
    // picks up the next dividend bit from the top of the quotient register,
    // which makes it WIDTH+1 bits wide. The trial subtract only needs WIDTH
    // bits: when the divisor fits, the true difference is below the divisor
    // and therefore below 2**WIDTH, so the modulo result is exact. When it
    // does not fit, the shifted value itself is below the divisor and its top
    // bit is zero, so the restore keeps the low WIDTH bits without loss.
    always_comb begin
        w_shift   = {r_rem, r_quo[WIDTH-1]};
        w_fits    = (w_shift >= {1'b0, r_div});
        w_diff    = w_shift[WIDTH-1:0] - r_div;
        w_remNext = w_fits ? w_diff : w_shift[WIDTH-1:0];
        w_quoNext = {r_quo[WIDTH-2:0], w_fits};
    end

    assign o_q    = w_quoNext;
    assign o_r    = w_remNext;
    assign o_last = (r_cnt == LAST_CNT);

    // Iteration state. The quotient register starts out holding the dividend
    // and shifts it out MSB first while quotient bits shift in at the bottom,
    // so after ITERS steps it holds the full quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
// HI/LO multiply/divide sequencer for the execute stage. Accepts
// MULT/MULTU/DIV/DIVU, runs a single-cycle registered multiply or a
// DIV_ITERS-cycle restoring divide, stalls the front of the pipe while busy
// and then commits the result to the architectural HI/LO registers. MTHI and
// MTLO writes are serviced whenever no operation is in flight.
//
// Ports
//   clk        in   core clock
//   rst        in   synchronous, active-high reset
//   start_i    in   mul/div op valid in E, held while stall_o is high
//   op_i       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i        in   rs operand (dividend / multiplicand)
//   b_i        in   rt operand (divisor / multiplier)
//   flush_i    in   exception/eret flush, cancels any operation in flight
//   hi_we_i    in   MTHI write enable
//   lo_we_i    in   MTLO write enable
//   wdata_i    in   MTHI/MTLO write data
//   stall_o    out  holds IF/ID/E (combinational)
//   done_o     out  one-cycle pulse when HI/LO first show a new result
//   hi_o       out  architectural HI
//   lo_o       out  architectural LO
//
// DIV_ITERS must equal WIDTH: the divider produces one quotient bit per step.
// ----------------------------------------------------------------------------
module muldiv_sequencer
    import mdu_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [1:0]         r_state;
    logic               r_negQ;
    logic               r_negR;
    logic [WIDTH-1:0]   r_absA;
    logic [WIDTH-1:0]   r_absB;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    md_op_e             w_op;
    logic               w_isDiv;
    logic               w_signedOp;
    logic               w_negA;
    logic               w_negB;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_bZero;
    logic               w_accept;
    logic               w_divStart;
    logic               w_divStep;
    logic               w_mtAllowed;
    logic               w_commitMul;
    logic               w_commitDiv;
    logic               w_commitDiv0;
    logic [2*WIDTH-1:0] w_prodMag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic               w_last;
    logic [WIDTH-1:0]   w_quoFix;
    logic [WIDTH-1:0]   w_remFix;
    logic               w_stall;

    // Operand conditioning for the incoming op. Both datapaths work on
    // magnitudes, so signed ops take the absolute value here and remember
    // which results need negating afterwards. The most negative value maps to
    // itself, which is still the correct unsigned magnitude.
    always_comb begin
        w_op       = md_op_e'(op_i);
        w_isDiv    = md_is_div(w_op);
        w_signedOp = md_is_signed(w_op);
        w_negA     = w_signedOp & a_i[WIDTH-1];
        w_negB     = w_signedOp & b_i[WIDTH-1];
        w_absA     = w_negA ? (~a_i + 1'b1) : a_i;
        w_absB     = w_negB ? (~b_i + 1'b1) : b_i;
        w_bZero    = (b_i == '0);
    end

    // Control decodes. An op is only taken from IDLE and never in the same
    // cycle as a flush. In DONE the same instruction is still sitting in E, so
    // start_i is deliberately ignored there. Commits are suppressed by a flush
    // so HI/LO keep their pre-operation values.
    always_comb begin
        w_accept     = (r_state == ST_IDLE) & start_i & ~flush_i;
        w_divStart   = w_accept & w_isDiv & ~w_bZero;
        w_commitDiv0 = w_accept & w_isDiv & w_bZero;
        w_divStep    = (r_state == ST_DIV) & ~flush_i;
        w_commitMul  = (r_state == ST_MUL) & ~flush_i;
        w_commitDiv  = w_divStep & w_last;
        w_mtAllowed  = (r_state == ST_IDLE) | (r_state == ST_DONE);
    end

    // Multiply on the latched magnitudes, then restore the sign. A single
    // unsigned multiplier therefore serves both MULT and MULTU.
    always_comb begin
        w_prodMag = {{WIDTH{1'b0}}, r_absA} * {{WIDTH{1'b0}}, r_absB};
        w_prod    = r_negQ ? (~w_prodMag + 1'b1) : w_prodMag;
    end

    // Divide sign fix-up: the quotient is negative when the operand signs
    // differ and the remainder follows the sign of the dividend, matching
    // truncating division. DIVU never sets the flags, so it passes through.
    always_comb begin
        w_quoFix = r_negQ ? (~w_q + 1'b1) : w_q;
        w_remFix = r_negR ? (~w_r + 1'b1) : w_r;
    end

    div_radix2 #(
        .WIDTH (WIDTH),
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_divStart),
        .i_step     (w_divStep),
        .i_abort    (flush_i),
        .i_dividend (w_absA),
        .i_divisor  (w_absB),
        .o_q        (w_q),
        .o_r        (w_r),
        .o_last     (w_last)
    );

    // Operand latch. Captured once when the op is accepted so the multiply
    // and the sign fix-up do not depend on the E-stage operands staying put.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_negQ <= 1'b0;
            r_negR <= 1'b0;
            r_absA <= '0;
            r_absB <= '0;
        end else if (w_accept) begin
            r_negQ <= w_negA ^ w_negB;
            r_negR <= w_negA;
            r_absA <= w_absA;
            r_absB <= w_absB;
        end
    end

    // Sequencer FSM. Multiplies spend one cycle in MUL, divides one cycle
    // per quotient bit in DIV, and a zero divisor skips straight to DONE.
    // DONE always lasts exactly one cycle so done_o is a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_isDiv) begin
                            r_state <= ST_MUL;
                        end else if (w_bZero) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    r_state <= ST_DONE;
                end
                ST_DIV: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO. MTHI/MTLO are applied first and a mul/div commit
    // on the same edge is written afterwards, so the commit wins. The
    // divide-by-zero result follows the common MIPS convention of HI getting
    // the dividend and LO all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_mtAllowed && hi_we_i) begin
                r_hi <= wdata_i;
            end
            if (w_mtAllowed && lo_we_i) begin
                r_lo <= wdata_i;
            end
            if (w_commitDiv0) begin
                r_hi <= a_i;
                r_lo <= '1;
            end else if (w_commitMul) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end else if (w_commitDiv) begin
                r_hi <= w_remFix;
                r_lo <= w_quoFix;
            end
        end
    end

    // Stall is combinational so the front end freezes in the very cycle an
    // op is accepted, and releases in the cycle a flush arrives.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: w_stall = w_accept;
            ST_MUL:  w_stall = ~flush_i;
            ST_DIV:  w_stall = ~flush_i;
            ST_DONE: w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    assign stall_o = w_stall;
    assign done_o  = (r_state == ST_DONE);
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. A cycle-level reference model
// tracks HI/LO, the remaining busy cycles and the done pulse using plain
// arithmetic on the operands; a compare process checks every DUT output
// against it on each falling edge. Directed sequences add literal checks on
// the documented example results and latencies.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [31:0] pHi;
    logic [31:0] pLo;
    int          mBusy;
    bit          mDone;
    bit          mValid = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[9];

    muldiv_sequencer #(
        .WIDTH     (32),
        .DIV_ITERS (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .hi_we_i (hi_we_i),
        .lo_we_i (lo_we_i),
        .wdata_i (wdata_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a hung run still ends with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural result and latency (start cycle to DONE cycle) of one op.
    function automatic void computeResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                          output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] up;
        case (op)
            2'b00: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                up  = sp;
                hi  = up[63:32];
                lo  = up[31:0];
                lat = 3;
            end
            2'b01: begin
                up  = 64'(a) * 64'(b);
                hi  = up[63:32];
                lo  = up[31:0];
                lat = 3;
            end
            default: begin
                if (b == 32'd0) begin
                    hi  = a;
                    lo  = 32'hFFFF_FFFF;
                    lat = 2;
                end else if (op == 2'b10) begin
                    sq  = longint'($signed(a)) / longint'($signed(b));
                    sr  = longint'($signed(a)) % longint'($signed(b));
                    lo  = sq[31:0];
                    hi  = sr[31:0];
                    lat = 34;
                end else begin
                    lo  = a / b;
                    hi  = a % b;
                    lat = 34;
                end
            end
        endcase
    endfunction

    // Reference model, advanced on each rising edge from the inputs of the
    // cycle just ending. mBusy counts the stall cycles still to go after the
    // current one; the result lands when it reaches zero.
    always @(posedge clk) begin
        int  lat;
        bit  newDone;
        if (rst) begin
            mHi    = 32'd0;
            mLo    = 32'd0;
            mBusy  = 0;
            mDone  = 1'b0;
            mValid = 1'b1;
        end else begin
            newDone = 1'b0;
            if (mBusy == 0) begin
                if (hi_we_i) mHi = wdata_i;
                if (lo_we_i) mLo = wdata_i;
            end
            if (flush_i) begin
                mBusy = 0;
            end else if (mBusy > 0) begin
                mBusy--;
                if (mBusy == 0) begin
                    mHi = pHi;
                    mLo = pLo;
                    newDone = 1'b1;
                end
            end else if (!mDone && start_i) begin
                computeResult(op_i, a_i, b_i, pHi, pLo, lat);
                mBusy = lat - 2;
                if (mBusy == 0) begin
                    mHi = pHi;
                    mLo = pLo;
                    newDone = 1'b1;
                end
            end
            mDone = newDone;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic expStall;
        if (mValid) begin
            if (mDone) expStall = 1'b0;
            else if (mBusy > 0) expStall = ~flush_i;
            else expStall = start_i & ~flush_i;
            checkOutput("model stall_o", 64'(stall_o), 64'(expStall));
            checkOutput("model done_o", 64'(done_o), 64'(mDone));
            checkOutput("model hi_o", 64'(hi_o), 64'(mHi));
            checkOutput("model lo_o", 64'(lo_o), 64'(mLo));
        end
    end

    // Drive one cycle of inputs just after the rising edge and return in the
    // middle of that cycle so the caller can look at the outputs.
    task automatic applyStimulus(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic fl, input logic hw, input logic lw, input logic [31:0] wd);
        @(posedge clk);
        #1;
        start_i = st;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        flush_i = fl;
        hi_we_i = hw;
        lo_we_i = lw;
        wdata_i = wd;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Holds start_i until the done pulse, counting stall cycles; returns at
    // the middle of the DONE cycle, or with doneCyc=-1 if it never came.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int doneCyc);
        stalls  = 0;
        doneCyc = -1;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b1, op, a, b, 1'b0, 1'b0, 1'b0, 32'd0);
            if (stall_o) stalls++;
            if (done_o) begin
                doneCyc = k;
                break;
            end
        end
    endtask

    initial begin
        int stalls;
        int doneCyc;
        int expLat;

        rst     = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = 32'd0;
        b_i     = 32'd0;
        flush_i = 1'b0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        wdata_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset stall_o", 64'(stall_o), 64'd0);
        checkOutput("reset done_o", 64'(done_o), 64'd0);
        checkOutput("reset hi_o", 64'(hi_o), 64'd0);
        checkOutput("reset lo_o", 64'(lo_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycle();

        // MULT -2 * 3
        runOp(2'b00, 32'hFFFF_FFFE, 32'd3, stalls, doneCyc);
        checkOutput("MULT stall cycles", 64'(stalls), 64'd2);
        checkOutput("MULT done cycle", 64'(doneCyc), 64'd3);
        checkOutput("MULT hi", 64'(hi_o), 64'hFFFF_FFFF);
        checkOutput("MULT lo", 64'(lo_o), 64'hFFFF_FFFA);
        idleCycle();
        checkOutput("MULT done pulse width", 64'(done_o), 64'd0);

        // MULTU 0xFFFFFFFF squared
        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, doneCyc);
        checkOutput("MULTU hi", 64'(hi_o), 64'hFFFF_FFFE);
        checkOutput("MULTU lo", 64'(lo_o), 64'h0000_0001);
        idleCycle();

        // DIV -7 / 2
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, stalls, doneCyc);
        checkOutput("DIV stall cycles", 64'(stalls), 64'd33);
        checkOutput("DIV done cycle", 64'(doneCyc), 64'd34);
        checkOutput("DIV lo", 64'(lo_o), 64'hFFFF_FFFD);
        checkOutput("DIV hi", 64'(hi_o), 64'hFFFF_FFFF);
        idleCycle();

        // DIV 7 / -2
        runOp(2'b10, 32'd7, 32'hFFFF_FFFE, stalls, doneCyc);
        checkOutput("DIV 7/-2 lo", 64'(lo_o), 64'hFFFF_FFFD);
        checkOutput("DIV 7/-2 hi", 64'(hi_o), 64'h0000_0001);
        idleCycle();

        // DIVU 100 / 0
        runOp(2'b11, 32'd100, 32'd0, stalls, doneCyc);
        checkOutput("DIVU/0 stall cycles", 64'(stalls), 64'd1);
        checkOutput("DIVU/0 done cycle", 64'(doneCyc), 64'd2);
        checkOutput("DIVU/0 hi", 64'(hi_o), 64'd100);
        checkOutput("DIVU/0 lo", 64'(lo_o), 64'hFFFF_FFFF);
        idleCycle();

        // Flush on cycle 10 of DIVU 100/7 with HI=0x11, LO=0x22 beforehand
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h11);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h22);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        checkOutput("pre-flush stall_o", 64'(stall_o), 64'd1);
        applyStimulus(1'b1, 2'b11, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("flush cycle stall_o", 64'(stall_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            idleCycle();
            checkOutput("post-flush done_o", 64'(done_o), 64'd0);
        end
        checkOutput("post-flush hi", 64'(hi_o), 64'h11);
        checkOutput("post-flush lo", 64'(lo_o), 64'h22);

        // start together with flush in IDLE is not accepted
        applyStimulus(1'b1, 2'b01, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("start+flush stall_o", 64'(stall_o), 64'd0);
        idleCycle();
        checkOutput("start+flush no op", 64'(stall_o | done_o), 64'd0);

        // MTLO 0x55 in the DONE cycle of MULTU 2*3
        applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 32'h55);
        checkOutput("MULTU 2*3 done_o", 64'(done_o), 64'd1);
        checkOutput("MULTU 2*3 lo", 64'(lo_o), 64'd6);
        idleCycle();
        checkOutput("MTLO in DONE lo", 64'(lo_o), 64'h55);
        checkOutput("MTLO in DONE hi", 64'(hi_o), 64'd0);

        // MTHI on the multiply commit edge loses to the product
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h99);
        applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 32'h77);
        applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("MTHI vs mul commit hi", 64'(hi_o), 64'd0);
        idleCycle();

        // MTHI+MTLO on the divide-by-zero commit edge lose to the result
        applyStimulus(1'b1, 2'b10, 32'd42, 32'd0, 1'b0, 1'b1, 1'b1, 32'hAB);
        applyStimulus(1'b1, 2'b10, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("div0 commit hi", 64'(hi_o), 64'd42);
        checkOutput("div0 commit lo", 64'(lo_o), 64'hFFFF_FFFF);
        idleCycle();

        // MTHI and MTLO together
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
        idleCycle();
        checkOutput("MTHI+MTLO hi", 64'(hi_o), 64'h1234_5678);
        checkOutput("MTHI+MTLO lo", 64'(lo_o), 64'h1234_5678);

        // Further vectors checked by the model on every cycle
        vecs[0] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[1] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE};
        vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'd1};
        vecs[3] = '{2'b11, 32'd5, 32'd10};
        vecs[4] = '{2'b11, 32'h8000_0000, 32'd3};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000};
        vecs[6] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{2'b10, 32'h8000_0000, 32'd0};
        vecs[8] = '{2'b10, 32'hDEAD_BEEF, 32'h0000_1234};
        for (int i = 0; i < 9; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, stalls, doneCyc);
            expLat = vecs[i].op[1] ? ((vecs[i].b == 32'd0) ? 2 : 34) : 3;
            checkOutput($sformatf("vector %0d done cycle", i), 64'(doneCyc), 64'(expLat));
            idleCycle();
        end

        // Reset in the middle of a divide
        runOp(2'b01, 32'd9, 32'd9, stalls, doneCyc);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 2'b10, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid-DIV reset stall_o", 64'(stall_o), 64'd0);
        checkOutput("mid-DIV reset hi", 64'(hi_o), 64'd0);
        checkOutput("mid-DIV reset lo", 64'(lo_o), 64'd0);
        idleCycle();
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
